// File: rtl/g18_wb_ctrl_if.sv
// Wishbone B3 classic bundle between the system bus master and the G18 flash read controller.
interface g18_wb_ctrl_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/g18_wb_ctrl.sv
// Read-only Wishbone slave for the 16-bit G18 BPI flash: each word read is two halfword reads, high first.
// Optional one-word prefetch buffer is enabled by defining G18_PREFETCH_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request (or serving a prefetch-buffer hit)
// RD_HI  | flash address = word|0, counting down to capture hi
// RD_LO  | flash address = word|1, counting down to capture lo
// DONE   | drop ack/err; optionally launch the next-word prefetch
module g18_wb_ctrl #(
   parameter int READ_WAIT = 1,
   parameter int ADR_WIDTH = 23
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   g18_wb_ctrl_if.slave         wb,
   output logic [ADR_WIDTH-1:0] g18_adr_o,
   input  logic [15:0]          g18_dat_i,
   output logic                 g18_wen_o
);
   localparam int CW = (READ_WAIT < 1) ? 1 : $clog2(READ_WAIT + 1);
   localparam int WW = ADR_WIDTH - 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(READ_WAIT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RD_HI = 2'd1;
   localparam logic [1:0] S_RD_LO = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [15:0]   hi_q;
   logic [WW-1:0] word_q;
   logic          req;
   logic [WW-1:0] req_word;
   logic          unused_wb;

   // A request is only new while no termination from the previous one is still visible.
   assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
   assign req_word  = wb.wb_adr_i[ADR_WIDTH:2];
   assign unused_wb = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:ADR_WIDTH+1], wb.wb_adr_i[1:0]};

`ifdef G18_PREFETCH_EN
   logic          pf_valid;
   logic          pf_busy;
   logic          pf_wait;
   logic          pf_next;
   logic [WW-1:0] pf_tag;
   logic [31:0]   pf_data;
   logic          pf_match;
   logic          pf_serve;
   logic          pf_abort;
   logic [WW-1:0] word_nxt;

   assign pf_match = pf_busy & req & ~wb.wb_we_i & (req_word == word_q);
   assign pf_serve = pf_wait | pf_match;
   assign pf_abort = pf_busy & req & ~pf_wait & (wb.wb_we_i | (req_word != word_q));
   assign word_nxt = word_q + WW'(1);
`endif

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state         <= S_IDLE;
         cnt           <= '0;
         hi_q          <= '0;
         word_q        <= '0;
         wb.wb_ack_o   <= 1'b0;
         wb.wb_err_o   <= 1'b0;
         wb.wb_dat_o   <= '0;
         g18_adr_o     <= '0;
         g18_wen_o     <= 1'b0;
`ifdef G18_PREFETCH_EN
         pf_valid      <= 1'b0;
         pf_busy       <= 1'b0;
         pf_wait       <= 1'b0;
         pf_next       <= 1'b0;
         pf_tag        <= '0;
         pf_data       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (wb.wb_we_i) begin
                     wb.wb_err_o <= 1'b1;
                     state       <= S_DONE;
`ifdef G18_PREFETCH_EN
                  end else if (pf_valid && (pf_tag == req_word)) begin
                     wb.wb_dat_o <= pf_data;
                     wb.wb_ack_o <= 1'b1;
                     word_q      <= req_word;
                     pf_valid    <= 1'b0;
                     pf_next     <= 1'b1;
                     state       <= S_DONE;
`endif
                  end else begin
                     word_q    <= req_word;
                     g18_adr_o <= {req_word, 1'b0};
                     cnt       <= CNT_LOAD;
                     g18_wen_o <= 1'b1;
                     state     <= S_RD_HI;
                  end
               end
            end
            S_RD_HI, S_RD_LO: begin
`ifdef G18_PREFETCH_EN
               if (pf_abort) begin
                  pf_busy <= 1'b0;
                  if (wb.wb_we_i) begin
                     wb.wb_err_o <= 1'b1;
                     g18_wen_o   <= 1'b0;
                     state       <= S_DONE;
                  end else begin
                     pf_valid  <= 1'b0;
                     word_q    <= req_word;
                     g18_adr_o <= {req_word, 1'b0};
                     cnt       <= CNT_LOAD;
                     g18_wen_o <= 1'b1;
                     state     <= S_RD_HI;
                  end
               end else begin
                  if (pf_match) pf_wait <= 1'b1;
`endif
                  if (cnt != '0) begin
                     cnt <= cnt - CW'(1);
                  end else if (state == S_RD_HI) begin
                     hi_q      <= g18_dat_i;
                     g18_adr_o <= g18_adr_o | ADR_WIDTH'(1);
                     cnt       <= CNT_LOAD;
                     state     <= S_RD_LO;
                  end else begin
                     g18_wen_o <= 1'b0;
`ifdef G18_PREFETCH_EN
                     pf_busy <= 1'b0;
                     pf_wait <= 1'b0;
                     if (pf_busy && !pf_serve) begin
                        pf_data  <= {hi_q, g18_dat_i};
                        pf_tag   <= word_q;
                        pf_valid <= 1'b1;
                        state    <= S_IDLE;
                     end else begin
                        pf_next <= 1'b1;
`endif
                        wb.wb_dat_o <= {hi_q, g18_dat_i};
                        wb.wb_ack_o <= 1'b1;
                        state       <= S_DONE;
`ifdef G18_PREFETCH_EN
                     end
`endif
                  end
`ifdef G18_PREFETCH_EN
               end
`endif
            end
            S_DONE: begin
               wb.wb_ack_o <= 1'b0;
               wb.wb_err_o <= 1'b0;
               state       <= S_IDLE;
`ifdef G18_PREFETCH_EN
               // Every completed read (demand or buffer hit) kicks off a fetch of the following word.
               if (pf_next) begin
                  pf_next   <= 1'b0;
                  pf_busy   <= 1'b1;
                  pf_valid  <= 1'b0;
                  word_q    <= word_nxt;
                  g18_adr_o <= {word_nxt, 1'b0};
                  cnt       <= CNT_LOAD;
                  g18_wen_o <= 1'b1;
                  state     <= S_RD_HI;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_g18_wb_ctrl.sv
// Self-checking bench for g18_wb_ctrl: table vectors, hand sequences and random reads/writes vs a word-level flash model.
module tb_g18_wb_ctrl;
   localparam int AW = 23;

   logic sys_clk_i = 1'b0;
   logic sys_rst_i = 1'b1;
   always #5 sys_clk_i = ~sys_clk_i;

   g18_wb_ctrl_if wb1 ();
   g18_wb_ctrl_if wb3 ();

   logic [AW-1:0] g18_adr1, g18_adr3;
   logic [15:0]   g18_dat1 = '0, g18_dat3 = '0;
   logic          g18_wen1, g18_wen3;

   g18_wb_ctrl #(.READ_WAIT(1), .ADR_WIDTH(AW)) dut1 (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .wb(wb1),
      .g18_adr_o(g18_adr1), .g18_dat_i(g18_dat1), .g18_wen_o(g18_wen1));

   g18_wb_ctrl #(.READ_WAIT(3), .ADR_WIDTH(AW)) dut3 (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .wb(wb3),
      .g18_adr_o(g18_adr3), .g18_dat_i(g18_dat3), .g18_wen_o(g18_wen3));

   // Flash model: explicit contents where the test needs them, a hash elsewhere; data registered one cycle.
   logic [15:0] ovr [int unsigned];

   function automatic logic [15:0] flash_rd(input logic [AW-1:0] a);
      int unsigned k;
      k = 32'(a);
      if (ovr.exists(k)) return ovr[k];
      return 16'((k * 32'h9E37) ^ (k >> 7));
   endfunction

   function automatic logic [31:0] word_rd(input logic [31:0] byte_adr);
      logic [AW-2:0] w;
      w = byte_adr[AW:2];
      return {flash_rd({w, 1'b0}), flash_rd({w, 1'b1})};
   endfunction

   always @(posedge sys_clk_i) begin
      g18_dat1 <= flash_rd(g18_adr1);
      g18_dat3 <= flash_rd(g18_adr3);
   end

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input int d, input logic act, input logic we, input logic [31:0] adr);
      if (d == 0) begin
         wb1.wb_cyc_i = act; wb1.wb_stb_i = act; wb1.wb_we_i = we; wb1.wb_adr_i = adr;
      end else begin
         wb3.wb_cyc_i = act; wb3.wb_stb_i = act; wb3.wb_we_i = we; wb3.wb_adr_i = adr;
      end
   endtask

   function automatic logic g_ack(input int d);
      return (d == 0) ? wb1.wb_ack_o : wb3.wb_ack_o;
   endfunction
   function automatic logic g_err(input int d);
      return (d == 0) ? wb1.wb_err_o : wb3.wb_err_o;
   endfunction
   function automatic logic [31:0] g_dat(input int d);
      return (d == 0) ? wb1.wb_dat_o : wb3.wb_dat_o;
   endfunction
   function automatic logic g_wen(input int d);
      return (d == 0) ? g18_wen1 : g18_wen3;
   endfunction
   function automatic logic [AW-1:0] g_adr(input int d);
      return (d == 0) ? g18_adr1 : g18_adr3;
   endfunction

   // One Wishbone access; lat counts edges after E0 (0 = terminated on E0 itself, -1 = timed out).
   task automatic txn(input int d, input logic we, input logic [31:0] adr,
                      output int lat, output logic is_err, output logic [31:0] rdata,
                      output logic wen_seen, output logic [AW-1:0] first_adr,
                      output int run0, output int run1, output logic stuck);
      int runs[$];
      logic [AW-1:0] prev;
      bit have;
      runs = {}; have = 0; prev = '0;
      lat = -1; is_err = 1'b0; rdata = '0; wen_seen = 1'b0; first_adr = '0;
      @(negedge sys_clk_i);
      drive(d, 1'b1, we, adr);
      for (int k = 0; k < 60 && lat < 0; k++) begin
         @(posedge sys_clk_i); #1;
         if (g_wen(d)) begin
            wen_seen = 1'b1;
            if (!have || g_adr(d) != prev) begin
               if (!have) first_adr = g_adr(d);
               runs.push_back(1);
               prev = g_adr(d);
               have = 1;
            end else begin
               runs[$] = runs[$] + 1;
            end
         end
         if (g_ack(d) || g_err(d)) begin
            lat = k; is_err = g_err(d); rdata = g_dat(d);
         end
      end
      drive(d, 1'b0, 1'b0, 32'h0);
      @(posedge sys_clk_i); #1;
      stuck = g_ack(d) | g_err(d);
      run0 = (runs.size() > 0) ? runs[0] : 0;
      run1 = (runs.size() > 1) ? runs[1] : 0;
   endtask

   typedef struct {
      logic          we;
      logic [31:0]   adr;
      logic [31:0]   exp_dat;
      int            exp_lat;
      logic          exp_err;
      logic [AW-1:0] exp_adr;
   } vec_t;

   vec_t vt[7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, r0, r1;
      logic er, ws, st, saw;
      logic [31:0] rd, last, exp;
      logic [AW-1:0] fa;

      ovr[32'h0] = 16'h1234;      ovr[32'h1] = 16'h5678;
      ovr[32'h2] = 16'hA5A5;      ovr[32'h3] = 16'h5A5A;
      ovr[32'h6] = 16'h0A0B;      ovr[32'h7] = 16'h0C0D;
      ovr[32'h80] = 16'h0101;     ovr[32'h81] = 16'h0202;
      ovr[32'h400000] = 16'hDEAD; ovr[32'h400001] = 16'hBEEF;
      ovr[32'h7FFFFE] = 16'hCAFE; ovr[32'h7FFFFF] = 16'hF00D;

      vt[0] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 4, 1'b0, 23'h000000};
      vt[1] = '{1'b0, 32'h0080_0000, 32'hDEAD_BEEF, 4, 1'b0, 23'h400000};
      vt[2] = '{1'b0, 32'h0100_0000, 32'h1234_5678, 4, 1'b0, 23'h000000};
      vt[3] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 0, 1'b1, 23'h000000};
      vt[4] = '{1'b0, 32'h0000_0003, 32'h1234_5678, 4, 1'b0, 23'h000000};
      vt[5] = '{1'b0, 32'h00FF_FFFC, 32'hCAFE_F00D, 4, 1'b0, 23'h7FFFFE};
      vt[6] = '{1'b0, 32'h0000_000C, 32'h0A0B_0C0D, 4, 1'b0, 23'h000006};

      wb1.wb_dat_i = 32'hFFFF_FFFF; wb1.wb_sel_i = 4'hF;
      wb3.wb_dat_i = 32'hFFFF_FFFF; wb3.wb_sel_i = 4'hF;
      drive(0, 1'b0, 1'b0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0);
      repeat (3) @(posedge sys_clk_i);
      @(negedge sys_clk_i);
      sys_rst_i = 1'b0;

      chk("rst_ack",  {31'b0, wb1.wb_ack_o}, 32'h0);
      chk("rst_err",  {31'b0, wb1.wb_err_o}, 32'h0);
      chk("rst_dat",  wb1.wb_dat_o, 32'h0);
      chk("rst_adr",  32'(g18_adr1), 32'h0);
      chk("rst_wen",  {31'b0, g18_wen1}, 32'h0);

      foreach (vt[i]) begin
         txn(0, vt[i].we, vt[i].adr, lat, er, rd, ws, fa, r0, r1, st);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
         chk($sformatf("v%0d_dat", i), rd, vt[i].exp_dat);
         chk($sformatf("v%0d_wen", i), {31'b0, ws}, {31'b0, ~vt[i].we});
         chk($sformatf("v%0d_one_cycle", i), {31'b0, st}, 32'h0);
         if (!vt[i].we) begin
            chk($sformatf("v%0d_fadr", i), 32'(fa), 32'(vt[i].exp_adr));
            chk($sformatf("v%0d_run_hi", i), 32'(r0), 32'd2);
            chk($sformatf("v%0d_run_lo", i), 32'(r1), 32'd2);
         end
      end

      // READ_WAIT = 3: ack on E0+8, each halfword address held four cycles.
      txn(1, 1'b0, 32'h4, lat, er, rd, ws, fa, r0, r1, st);
      chk("rw3_lat", 32'(lat), 32'd8);
      chk("rw3_dat", rd, 32'hA5A5_5A5A);
      chk("rw3_fadr", 32'(fa), 32'h2);
      chk("rw3_run_hi", 32'(r0), 32'd4);
      chk("rw3_run_lo", 32'(r1), 32'd4);

      // Reset while in RD_LO aborts the read without an ack.
      @(negedge sys_clk_i);
      drive(0, 1'b1, 1'b0, 32'h0);
      repeat (3) @(posedge sys_clk_i);
      @(negedge sys_clk_i);
      sys_rst_i = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0);
      @(posedge sys_clk_i); #1;
      chk("mid_rst_ack", {31'b0, wb1.wb_ack_o}, 32'h0);
      chk("mid_rst_dat", wb1.wb_dat_o, 32'h0);
      chk("mid_rst_adr", 32'(g18_adr1), 32'h0);
      chk("mid_rst_wen", {31'b0, g18_wen1}, 32'h0);
      @(negedge sys_clk_i);
      sys_rst_i = 1'b0;
      saw = 1'b0;
      repeat (6) begin
         @(posedge sys_clk_i); #1;
         saw = saw | wb1.wb_ack_o;
      end
      chk("mid_rst_no_ack", {31'b0, saw}, 32'h0);
      txn(0, 1'b0, 32'h0, lat, er, rd, ws, fa, r0, r1, st);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_dat", rd, 32'h1234_5678);
      last = rd;

`ifdef G18_PREFETCH_EN
      repeat (10) @(posedge sys_clk_i);
      txn(0, 1'b0, 32'h4, lat, er, rd, ws, fa, r0, r1, st);
      chk("pf_hit_lat", 32'(lat), 32'd0);
      chk("pf_hit_dat", rd, 32'hA5A5_5A5A);
      txn(0, 1'b0, 32'h0, lat, er, rd, ws, fa, r0, r1, st);
      chk("pf_abort0_lat", 32'(lat), 32'd4);
      chk("pf_abort0_dat", rd, 32'h1234_5678);
      txn(0, 1'b0, 32'h100, lat, er, rd, ws, fa, r0, r1, st);
      chk("pf_abort1_lat", 32'(lat), 32'd4);
      chk("pf_abort1_dat", rd, 32'h0101_0202);
      last = rd;
`endif

      // Random traffic against the word-level model.
      for (int n = 0; n < 40; n++) begin
         logic we;
         logic [31:0] adr;
         we  = ($urandom_range(0, 3) == 0);
         adr = $urandom;
         repeat ($urandom_range(0, 3)) @(posedge sys_clk_i);
         txn(0, we, adr, lat, er, rd, ws, fa, r0, r1, st);
         exp = we ? last : word_rd(adr);
         chk($sformatf("rnd%0d_dat", n), rd, exp);
         chk($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, we});
`ifdef G18_PREFETCH_EN
         chk($sformatf("rnd%0d_lat", n), {31'b0, (lat >= 0) && (lat <= 4) && (!we || lat == 0)}, 32'h1);
`else
         chk($sformatf("rnd%0d_lat", n), 32'(lat), we ? 32'd0 : 32'd4);
`endif
         last = exp;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
